// File: rtl/riscv_configs.sv
// Shared RV32I core constants: data width, result-source and forward-select
// encodings, and the hazard controller state encoding.
package riscv_configs;
  localparam int XLEN = 32;

  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } hz_state_e;
endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX operand forwarding selects and load-use detection.
// No state; the M stage result is preferred over the older W stage result.
module hazard_fwd_unit
  import riscv_configs::*;
(
  input  logic [4:0] rs1_addr_d,
  input  logic [4:0] rs2_addr_d,
  input  logic [4:0] rs1_addr_e,
  input  logic [4:0] rs2_addr_e,
  input  logic [4:0] rd_addr_e,
  input  logic [1:0] result_src_e,
  input  logic [4:0] rd_addr_m,
  input  logic       reg_wr_en_m,
  input  logic [4:0] rd_addr_w,
  input  logic       reg_wr_en_w,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       load_use
);

  logic m_live;
  logic w_live;

  // x0 is never a real producer, so writes to it must not forward.
  assign m_live = reg_wr_en_m && (rd_addr_m != 5'd0);
  assign w_live = reg_wr_en_w && (rd_addr_w != 5'd0);

  always_comb begin
    fwd_a = FWD_RF;
    if (m_live && (rd_addr_m == rs1_addr_e)) begin
      fwd_a = FWD_M;
    end else if (w_live && (rd_addr_w == rs1_addr_e)) begin
      fwd_a = FWD_W;
    end

    fwd_b = FWD_RF;
    if (m_live && (rd_addr_m == rs2_addr_e)) begin
      fwd_b = FWD_M;
    end else if (w_live && (rd_addr_w == rs2_addr_e)) begin
      fwd_b = FWD_W;
    end
  end

  assign load_use = (result_src_e == RES_LOAD) && (rd_addr_e != 5'd0) &&
                    ((rd_addr_e == rs1_addr_d) || (rd_addr_e == rs2_addr_d));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, stall/flush,
// data-memory wait sequencing with timeout halt, and saturating perf counters.
module pipeline_hazard_ctrl
  import riscv_configs::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_rs1_addrD,
  input  logic [4:0]       i_rs2_addrD,
  input  logic [4:0]       i_rs1_addrE,
  input  logic [4:0]       i_rs2_addrE,
  input  logic [4:0]       i_rd_addrE,
  input  logic [1:0]       i_result_srcE,
  input  logic             i_pc_srcE,
  input  logic [4:0]       i_rd_addrM,
  input  logic             i_reg_wr_enM,
  input  logic             i_mem_reqM,
  input  logic             i_dmem_ready,
  input  logic [4:0]       i_rd_addrW,
  input  logic             i_reg_wr_enW,
  input  logic             i_cnt_clr,
  output logic [1:0]       o_fwd_aE,
  output logic [1:0]       o_fwd_bE,
  output logic             o_stallF,
  output logic             o_stallD,
  output logic             o_flushD,
  output logic             o_flushE,
  output logic             o_stallEM,
  output logic             o_flushW,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]        fwd_a, fwd_b;
  logic              lu, mw, halted, br_flush;
  logic              stall_f, stall_d, flush_d, flush_e, stall_em, flush_w;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  hazard_fwd_unit u_fwd (
    .rs1_addr_d   (i_rs1_addrD),
    .rs2_addr_d   (i_rs2_addrD),
    .rs1_addr_e   (i_rs1_addrE),
    .rs2_addr_e   (i_rs2_addrE),
    .rd_addr_e    (i_rd_addrE),
    .result_src_e (i_result_srcE),
    .rd_addr_m    (i_rd_addrM),
    .reg_wr_en_m  (i_reg_wr_enM),
    .rd_addr_w    (i_rd_addrW),
    .reg_wr_en_w  (i_reg_wr_enW),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .load_use     (lu)
  );

  assign mw     = i_mem_reqM && !i_dmem_ready;
  assign halted = (state == ST_HALT);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // wait_cnt holds the number of consecutive not-ready cycles already seen.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (mw) begin
          wait_cnt_nxt = WAIT_W'(1);
          state_nxt    = (MEM_TIMEOUT == 1) ? ST_HALT : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (!mw) begin
          state_nxt = ST_RUN;
        end else if (MEM_TIMEOUT != 0) begin
          if ((wait_cnt + WAIT_W'(1)) == WAIT_LAST) begin
            state_nxt = ST_HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  // A frozen pipeline holds a pending branch; it is applied after release.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    stall_em = 1'b0;
    flush_w  = 1'b0;
    br_flush = 1'b0;
    if (i_rstn) begin
      if (halted || mw) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_em = 1'b1;
        flush_w  = 1'b1;
      end else if (i_pc_srcE) begin
        flush_d  = 1'b1;
        flush_e  = 1'b1;
        br_flush = 1'b1;
      end else if (lu) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        flush_e  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (i_cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && !halted && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (br_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_fwd_aE    = i_rstn ? fwd_a : FWD_RF;
  assign o_fwd_bE    = i_rstn ? fwd_b : FWD_RF;
  assign o_stallF    = stall_f;
  assign o_stallD    = stall_d;
  assign o_flushD    = flush_d;
  assign o_flushE    = flush_e;
  assign o_stallEM   = stall_em;
  assign o_flushW    = flush_w;
  assign o_halted    = halted;
  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: random and directed cycles are
// scored against a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int TMO   = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       pcsrc, wem, wew, memreq, rdy, clr;
  } stim_t;

  typedef struct packed {
    logic [1:0]       fa, fb;
    logic             sf, sd, fd, fe, sem, fw, h;
    logic [CNT_W-1:0] sc, fc;
  } obs_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0] rsrc;
  logic pcsrc, wem, wew, memreq, rdy, clr;
  logic [1:0] fa, fb;
  logic sf, sd, fd, fe, sem, fw, h;
  logic [CNT_W-1:0] sc, fc;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_rs1_addrD(rs1d), .i_rs2_addrD(rs2d), .i_rs1_addrE(rs1e), .i_rs2_addrE(rs2e),
    .i_rd_addrE(rde), .i_result_srcE(rsrc), .i_pc_srcE(pcsrc),
    .i_rd_addrM(rdm), .i_reg_wr_enM(wem), .i_mem_reqM(memreq), .i_dmem_ready(rdy),
    .i_rd_addrW(rdw), .i_reg_wr_enW(wew), .i_cnt_clr(clr),
    .o_fwd_aE(fa), .o_fwd_bE(fb), .o_stallF(sf), .o_stallD(sd), .o_flushD(fd),
    .o_flushE(fe), .o_stallEM(sem), .o_flushW(fw), .o_halted(h),
    .o_stall_cnt(sc), .o_flush_cnt(fc)
  );

  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0, n_mis = 0, cyc = 0;

  // Reference model state: halt flag, consecutive not-ready run, counters.
  bit m_halt = 1'b0;
  int m_nr = 0, m_sc = 0, m_fc = 0;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] r_m,
                                         input logic w_m, input logic [4:0] r_w,
                                         input logic w_w);
    if (w_m && r_m != 0 && r_m == rs) return 2'b10;
    if (w_w && r_w != 0 && r_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rs1d = 0; s.rs2d = 0; s.rs1e = 0; s.rs2e = 0; s.rde = 0; s.rdm = 0; s.rdw = 0;
    s.rsrc = 0; s.pcsrc = 0; s.wem = 0; s.wew = 0; s.memreq = 0; s.rdy = 1; s.clr = 0;
    return s;
  endfunction

  task automatic cycle(input stim_t s, input bit in_rst, input string nm);
    obs_t e;
    bit   lu, mw, frozen;
    @(negedge clk);
    cyc++;
    rs1d = s.rs1d; rs2d = s.rs2d; rs1e = s.rs1e; rs2e = s.rs2e; rde = s.rde;
    rdm = s.rdm; rdw = s.rdw; rsrc = s.rsrc; pcsrc = s.pcsrc; wem = s.wem;
    wew = s.wew; memreq = s.memreq; rdy = s.rdy; clr = s.clr;
    e = '0;
    if (in_rst) begin
      rstn = 1'b0;
      m_halt = 0; m_nr = 0; m_sc = 0; m_fc = 0;
    end else begin
      rstn = 1'b1;
      lu = (s.rsrc == 2'b01) && (s.rde != 0) && (s.rde == s.rs1d || s.rde == s.rs2d);
      mw = s.memreq && !s.rdy;
      frozen = m_halt || mw;
      e.fa = fwd_sel(s.rs1e, s.rdm, s.wem, s.rdw, s.wew);
      e.fb = fwd_sel(s.rs2e, s.rdm, s.wem, s.rdw, s.wew);
      e.h  = m_halt;
      e.sc = CNT_W'(m_sc);
      e.fc = CNT_W'(m_fc);
      if (frozen) begin
        e.sf = 1; e.sd = 1; e.sem = 1; e.fw = 1;
      end else if (s.pcsrc) begin
        e.fd = 1; e.fe = 1;
      end else if (lu) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end
      if (s.clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (e.sf && !m_halt && m_sc < CMAX) m_sc++;
        if (!frozen && s.pcsrc && m_fc < CMAX) m_fc++;
      end
      if (!m_halt) begin
        if (mw) begin
          m_nr++;
          if (TMO != 0 && m_nr >= TMO) m_halt = 1;
        end else begin
          m_nr = 0;
        end
      end
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    obs_t  e, a;
    string nm;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {fa, fb, sf, sd, fd, fe, sem, fw, h, sc, fc};
        n_vec++;
        if (a !== e) begin
          n_mis++;
          $display("FAIL %s cyc %0d: got fa=%b fb=%b sF=%b sD=%b fD=%b fE=%b sEM=%b fW=%b h=%b sc=%0d fc=%0d, want fa=%b fb=%b sF=%b sD=%b fD=%b fE=%b sEM=%b fW=%b h=%b sc=%0d fc=%0d",
                   nm, cyc, a.fa, a.fb, a.sf, a.sd, a.fd, a.fe, a.sem, a.fw, a.h, a.sc, a.fc,
                   e.fa, e.fb, e.sf, e.sd, e.fd, e.fe, e.sem, e.fw, e.h, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    stim_t s;
    cycle(idle(), 1, "reset");
    cycle(idle(), 1, "reset");

    for (int i = 0; i < 300; i++) begin
      s.rs1d = 5'($urandom_range(0, 7)); s.rs2d = 5'($urandom_range(0, 7));
      s.rs1e = 5'($urandom_range(0, 7)); s.rs2e = 5'($urandom_range(0, 7));
      s.rde  = 5'($urandom_range(0, 7)); s.rdm  = 5'($urandom_range(0, 7));
      s.rdw  = 5'($urandom_range(0, 7)); s.rsrc = 2'($urandom_range(0, 3));
      s.pcsrc = ($urandom_range(0, 3) == 0);
      s.wem = $urandom_range(0, 1); s.wew = $urandom_range(0, 1);
      s.memreq = ($urandom_range(0, 9) < 3);
      s.rdy = (m_nr >= TMO - 1) ? 1'b1 : ($urandom_range(0, 9) < 6);
      s.clr = ($urandom_range(0, 29) == 0);
      cycle(s, 0, "random");
    end

    s = idle(); s.rdm = 5; s.wem = 1; s.rs1e = 5;
    cycle(s, 0, "fwd_m");
    s.rdw = 5; s.wew = 1;
    cycle(s, 0, "fwd_m_over_w");
    s.rs2e = 5; s.rdm = 6;
    cycle(s, 0, "fwd_w");
    s.rdm = 0; s.rdw = 0; s.rs1e = 0; s.rs2e = 0;
    cycle(s, 0, "fwd_x0");

    s = idle(); s.clr = 1;
    cycle(s, 0, "clr");
    s = idle(); s.rsrc = 2'b01; s.rde = 7; s.rs2d = 7;
    cycle(s, 0, "load_use");
    cycle(idle(), 0, "after_lu");
    s.pcsrc = 1;
    cycle(s, 0, "branch_over_lu");
    cycle(idle(), 0, "after_branch");

    s = idle(); s.memreq = 1; s.rdy = 0; s.pcsrc = 1;
    for (int i = 0; i < 3; i++) cycle(s, 0, "mem_wait");
    s.rdy = 1;
    cycle(s, 0, "mem_release");
    cycle(idle(), 0, "after_mem");

    s = idle(); s.rsrc = 2'b01; s.rde = 3; s.rs1d = 3;
    for (int i = 0; i < 20; i++) cycle(s, 0, "stall_sat");
    s.clr = 1;
    cycle(s, 0, "clr_in_stall");
    cycle(idle(), 0, "after_clr");

    s = idle(); s.memreq = 1; s.rdy = 0;
    for (int i = 0; i < 6; i++) cycle(s, 0, "timeout");
    s.rdy = 1; s.pcsrc = 1;
    for (int i = 0; i < 2; i++) cycle(s, 0, "halt_sticky");
    cycle(idle(), 1, "reset_halt");
    cycle(idle(), 0, "post_reset");
    s = idle(); s.memreq = 1; s.rdy = 0;
    cycle(s, 0, "wait_pre_reset");
    cycle(s, 1, "reset_mid_wait");
    cycle(idle(), 0, "post_reset2");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline.
- Generates the forwarding selects for the EX stage operands.
- Generates stall and flush controls for the IF/ID, ID/EX (drives its i_clear), EX/MEM and MEM/WB registers.
- Sequences data-memory wait states and halts the core when a memory access times out.
- Keeps saturating stall and flush performance counters.

Parameters:
- XLEN, 32, data width (from riscv_configs).
- CNT_W, 32, width of each performance counter.
- MEM_TIMEOUT, 16, number of consecutive not-ready memory cycles before HALT; 0 disables the timeout.

Ports:
- i_clk  in  1  core clock
- i_rstn  in  1  asynchronous active-low reset
- i_rs1_addrD  in  5  rs1 index in decode
- i_rs2_addrD  in  5  rs2 index in decode
- i_rs1_addrE  in  5  rs1 index in execute
- i_rs2_addrE  in  5  rs2 index in execute
- i_rd_addrE  in  5  rd index in execute
- i_result_srcE  in  2  result source in execute; 2'b01 means load
- i_pc_srcE  in  1  taken branch, jal or jalr resolved in execute
- i_rd_addrM  in  5  rd index in memory stage
- i_reg_wr_enM  in  1  register write enable in memory stage
- i_mem_reqM  in  1  load or store active in memory stage
- i_dmem_ready  in  1  data memory completes the access this cycle
- i_rd_addrW  in  5  rd index in writeback
- i_reg_wr_enW  in  1  register write enable in writeback
- i_cnt_clr  in  1  synchronous clear of both counters
- o_fwd_aE  out  2  operand A select: 00 regfile, 10 from M, 01 from W
- o_fwd_bE  out  2  operand B select, same encoding
- o_stallF  out  1  hold PC
- o_stallD  out  1  hold IF/ID
- o_flushD  out  1  clear IF/ID
- o_flushE  out  1  clear ID/EX
- o_stallEM  out  1  hold ID/EX and EX/MEM
- o_flushW  out  1  insert bubble into MEM/WB
- o_halted  out  1  core halted after a memory timeout
- o_stall_cnt  out  CNT_W  count of stall cycles
- o_flush_cnt  out  CNT_W  count of control-flush cycles

Behaviour:
- Reset values: counters 0, FSM in RUN, o_halted 0. All control outputs are combinational and evaluate to 0 while in reset.
- Forwarding (combinational):
  - Operand A: 10 if i_reg_wr_enM and i_rd_addrM equals i_rs1_addrE and is not 0.
  - Otherwise 01 if the same conditions hold for the W stage.
  - Otherwise 00. M has priority over W.
  - Operand B: identical, using i_rs2_addrE.
- Load-use (lu): i_result_srcE equals 01, i_rd_addrE is not 0, and i_rd_addrE matches i_rs1_addrD or i_rs2_addrD.
- Memory wait (mw): i_mem_reqM is 1 and i_dmem_ready is 0.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN: if mw, go to MEM_WAIT and set wait_cnt to 1.
  - MEM_WAIT: if i_dmem_ready, return to RUN. If still not ready, increment wait_cnt; when the MEM_TIMEOUT-th consecutive not-ready cycle occurs, go to HALT at the next edge.
  - HALT: sticky until reset; o_halted is 1.
- Output priority, highest first:
  - HALT or mw: o_stallF, o_stallD and o_stallEM are 1; o_flushW is 1; o_flushD and o_flushE are 0. A pending i_pc_srcE is held by the frozen pipeline and applied after release.
  - i_pc_srcE: o_flushD and o_flushE are 1; no stall, so the target is fetched. This overrides lu because the loaded-into instruction is discarded.
  - lu: o_stallF and o_stallD are 1 and o_flushE is 1, inserting one bubble. The load moves to M on the next cycle, so the stall lasts exactly 1 cycle.
  - Otherwise all controls are 0.
- The mw stall is combinational in the first not-ready cycle, so there is no lost cycle.
- Counters:
  - o_stall_cnt increments on each cycle with o_stallF = 1, excluding HALT.
  - o_flush_cnt increments on each cycle where i_pc_srcE caused the flush.
  - Both saturate at all-ones.
  - i_cnt_clr wins over increment in the same cycle.
- Reset mid-wait: the FSM returns to RUN and the counters clear immediately.

Decomposition:
- Shared package riscv_configs: XLEN, the result_src encoding constant RES_LOAD = 2'b01, the forward-select constants FWD_RF, FWD_M and FWD_W, and the FSM state encodings.
- One natural sub-module: hazard_fwd_unit, the purely combinational forwarding and lu detect. The FSM, priority logic and counters stay in the top.

Test Plan:
1. ALU-to-ALU dependency: add x5 in M with wr_en 1, rs1E equal to 5 → o_fwd_aE = 10. Same rd also in W → still 10 (M priority). rd set to 0 → 00.
2. Load-use: result_srcE = 01, rdE = 7, rs2D = 7 → one cycle of o_stallF = 1, o_stallD = 1, o_flushE = 1. The next cycle is clean. o_stall_cnt goes 0 → 1.
3. Taken branch together with lu in the same cycle → o_flushD = 1, o_flushE = 1, o_stallF = 0. o_flush_cnt increments by 1 and o_stall_cnt is unchanged.
4. Memory wait: mem_reqM = 1 with ready low for 3 cycles, then high → stall outputs and o_flushW are 1 for exactly 3 cycles, and the FSM returns to RUN.
5. Timeout with MEM_TIMEOUT = 4: ready held low → o_halted = 1 from the 5th cycle and stays 1 after ready rises. i_rstn low → o_halted = 0 and counters = 0.
6. Counter saturation with CNT_W = 4: force 20 stall cycles → o_stall_cnt = 15. Assert i_cnt_clr during a stall → o_stall_cnt = 0.
